wb_retire_unit: RTL and testbench
=================================

// Module: wb_retire_unit
// PURPOSE
//  Consumer end of the dual-slot writeback interface. Sits after the writeback
//  stage and owns the architectural integer register file (4 read ports for
//  dual-issue operand fetch). Counts retired instructions and turns the
//  writeback redirect into a held valid/ready redirect toward fetch, plus a
//  one-cycle flush pulse.
// PARAMETERS
//  XLEN   64  register/PC width
//  ILEN   32  instruction word width
//  CNT_W  64  instret counter width
// PORTS
//  clk                   in   1     clock
//  rst_n                 in   1     synchronous active-low reset
//  inst{0,1}_wb_valid_i  in   1     slot retires this cycle
//  inst{0,1}_wb_rd_i     in   5     destination register
//  inst{0,1}_wb_value_i  in   XLEN  result value
//  inst{0,1}_wb_pc_i     in   XLEN  PC of retiring instruction
//  inst{0,1}_wb_inst_i   in   ILEN  instruction word
//  wb_redirect_i         in   1     redirect request from writeback
//  wb_redirect_pc_i      in   XLEN  redirect target
//  rs{0..3}_addr_i       in   5     read-port addresses
//  rs{0..3}_data_o       out  XLEN  read-port data (combinational)
//  fetch_redirect_valid_o out 1     redirect pending toward fetch
//  fetch_redirect_pc_o   out  XLEN  held redirect target
//  fetch_redirect_ready_i in  1     fetch accepts redirect
//  flush_o               out  1     one-cycle squash pulse to younger stages
//  instret_o             out  CNT_W retired-instruction count
//  retire_pc_o           out  XLEN  PC of youngest instruction retired last
//  retire_inst_o         out  ILEN  instruction word of same
// BEHAVIOUR
//  - Reset (sync, rst_n=0 at posedge): x1..x31=0, FSM=IDLE, valid_o=0, pc_o=0,
//    flush_o=0, instret_o=0, retire_pc_o=0, retire_inst_o=0.
//  - x0: reads always 0; writes to rd=0 dropped (instruction still counted).
//  - Write: at posedge for each valid slot while FSM=IDLE. Both slots valid
//    with same rd!=0: inst1 value wins (program order).
//  - Read: combinational from array; a write is visible the cycle after it.
//  - instret_o += inst0_valid + inst1_valid (0/1/2) per accepted cycle; wraps
//    modulo 2^CNT_W.
//  - retire_pc_o/retire_inst_o: registered from inst1 if valid else inst0;
//    held when neither slot valid.
//  - Redirect FSM, states IDLE, HOLD:
//    IDLE: wb_redirect_i=1 -> latch wb_redirect_pc_i, go HOLD; flush_o=1 and
//      fetch_redirect_valid_o=1 from the next cycle. Writes/counting of the
//      slots in that same cycle still occur (redirecting instruction retires).
//    HOLD: valid_o=1, pc_o stable; flush_o=0 after its single cycle.
//      fetch_redirect_ready_i=1 -> IDLE next cycle (valid_o drops).
//      In HOLD all wb valids and wb_redirect_i are wrong-path: no regfile
//      write, no count, no retire_pc update, no pc overwrite.
//  - Reset mid-HOLD: returns to IDLE, pending redirect discarded.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: rs*_data_o forwards the same-cycle write value
//    when rs addr == a valid, accepted write rd (rd!=0); inst1 has priority.
//  Not defined: no forwarding; reads return the pre-write value that cycle.
// TESTING
//  1. Reset, then inst0 valid rd=5 value=0xAA -> next cycle rs0_addr=5 reads
//     0xAA; instret_o=1.
//  2. Both slots valid rd=7, values 0x11/0x22 -> x7=0x22; instret_o +2.
//  3. Write rd=0 value=0xFF -> x0 reads 0; instret_o still increments.
//  4. wb_redirect_i=1 pc=0x8000_0100 -> next cycle valid_o=1, pc_o=0x8000_0100,
//     flush_o=1 exactly one cycle; ready_i held 0 for 3 cycles keeps valid_o;
//     slots valid during HOLD leave regfile/instret unchanged; ready_i=1 ->
//     IDLE next cycle.
//  5. Preload instret_o=2^CNT_W-1 (CNT_W=8 build), retire 2 -> instret_o=1.
//  6. REGFILE_BYPASS_EN build: write rd=3 value=0x5 with rs1_addr=3 same cycle
//     -> rs1_data_o=0x5; without macro -> old value (0 after reset).

Source files
------------

// File: rtl/wb_retire_unit_if.sv
// Writeback-to-retire bundle: two retiring slots, the redirect request,
// and the valid/ready redirect handshake toward fetch.
interface wb_retire_unit_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            inst0_wb_valid_i;
    logic [4:0]      inst0_wb_rd_i;
    logic [XLEN-1:0] inst0_wb_value_i;
    logic [XLEN-1:0] inst0_wb_pc_i;
    logic [ILEN-1:0] inst0_wb_inst_i;
    logic            inst1_wb_valid_i;
    logic [4:0]      inst1_wb_rd_i;
    logic [XLEN-1:0] inst1_wb_value_i;
    logic [XLEN-1:0] inst1_wb_pc_i;
    logic [ILEN-1:0] inst1_wb_inst_i;
    logic            wb_redirect_i;
    logic [XLEN-1:0] wb_redirect_pc_i;
    logic            fetch_redirect_valid_o;
    logic [XLEN-1:0] fetch_redirect_pc_o;
    logic            fetch_redirect_ready_i;

    modport master (
        output inst0_wb_valid_i, inst0_wb_rd_i, inst0_wb_value_i,
        output inst0_wb_pc_i, inst0_wb_inst_i,
        output inst1_wb_valid_i, inst1_wb_rd_i, inst1_wb_value_i,
        output inst1_wb_pc_i, inst1_wb_inst_i,
        output wb_redirect_i, wb_redirect_pc_i, fetch_redirect_ready_i,
        input  fetch_redirect_valid_o, fetch_redirect_pc_o
    );

    modport slave (
        input  inst0_wb_valid_i, inst0_wb_rd_i, inst0_wb_value_i,
        input  inst0_wb_pc_i, inst0_wb_inst_i,
        input  inst1_wb_valid_i, inst1_wb_rd_i, inst1_wb_value_i,
        input  inst1_wb_pc_i, inst1_wb_inst_i,
        input  wb_redirect_i, wb_redirect_pc_i, fetch_redirect_ready_i,
        output fetch_redirect_valid_o, fetch_redirect_pc_o
    );
endinterface

// File: rtl/wb_retire_unit.sv
// Dual-slot retire: regfile, instret, redirect handshake and flush pulse.
// Optional REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module wb_retire_unit #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_retire_unit_if.slave  wb,
    input  logic [4:0]       rs0_addr_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       rs3_addr_i,
    output logic [XLEN-1:0]  rs0_data_o,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  rs3_data_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [XLEN-1:0]  retire_pc_o,
    output logic [ILEN-1:0]  retire_inst_o
);
    typedef enum logic {IDLE, HOLD} state_e;

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] redir_pc_q;
    logic            flush_q;
    logic            accept;
    logic            v0;
    logic            v1;
    logic            we0;
    logic            we1;
    logic [4:0]      ra [4];
    logic [XLEN-1:0] rdata [4];

    // Slots presented while a redirect is held are wrong-path.
    assign accept = (state_q == IDLE);
    assign v0  = accept & wb.inst0_wb_valid_i;
    assign v1  = accept & wb.inst1_wb_valid_i;
    assign we0 = v0 & (wb.inst0_wb_rd_i != 5'd0);
    assign we1 = v1 & (wb.inst1_wb_rd_i != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (we1 && wb.inst1_wb_rd_i == 5'(i))
                    regs[i] <= wb.inst1_wb_value_i;
                else if (we0 && wb.inst0_wb_rd_i == 5'(i))
                    regs[i] <= wb.inst0_wb_value_i;
            end
        end
    end

    assign ra[0] = rs0_addr_i;
    assign ra[1] = rs1_addr_i;
    assign ra[2] = rs2_addr_i;
    assign ra[3] = rs3_addr_i;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata[p] = regs[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (we1 && wb.inst1_wb_rd_i == ra[p])
                rdata[p] = wb.inst1_wb_value_i;
            else if (we0 && wb.inst0_wb_rd_i == ra[p])
                rdata[p] = wb.inst0_wb_value_i;
`endif
            if (ra[p] == 5'd0) rdata[p] = '0;
        end
    end

    assign rs0_data_o = rdata[0];
    assign rs1_data_o = rdata[1];
    assign rs2_data_o = rdata[2];
    assign rs3_data_o = rdata[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_o     <= '0;
            retire_pc_o   <= '0;
            retire_inst_o <= '0;
        end else begin
            instret_o <= instret_o + CNT_W'(v0) + CNT_W'(v1);
            if (v1) begin
                retire_pc_o   <= wb.inst1_wb_pc_i;
                retire_inst_o <= wb.inst1_wb_inst_i;
            end else if (v0) begin
                retire_pc_o   <= wb.inst0_wb_pc_i;
                retire_inst_o <= wb.inst0_wb_inst_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            redir_pc_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= accept & wb.wb_redirect_i;
            if (accept && wb.wb_redirect_i)
                redir_pc_q <= wb.wb_redirect_pc_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (wb.wb_redirect_i) state_d = HOLD;
            HOLD: if (wb.fetch_redirect_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb.fetch_redirect_valid_o = (state_q == HOLD);
        wb.fetch_redirect_pc_o    = redir_pc_q;
        flush_o                   = flush_q;
    end
endmodule

// File: tb/tb_wb_retire_unit.sv
// Randomized bench for wb_retire_unit against a rule-level model;
// built with an 8-bit instret so counter wrap is exercised.
module tb_wb_retire_unit;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int CNT_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [4:0]      rs_addr [4];
    logic [XLEN-1:0] rs_data [4];
    logic            flush;
    logic [CNT_W-1:0] instret;
    logic [XLEN-1:0] retire_pc;
    logic [ILEN-1:0] retire_inst;

    int n_checks = 0;
    int n_pass   = 0;

    logic [XLEN-1:0]  m_rf [32];
    logic [CNT_W-1:0] m_cnt;
    logic [XLEN-1:0]  m_rpc;
    logic [ILEN-1:0]  m_rinst;
    logic             m_hold;
    logic [XLEN-1:0]  m_pc;
    logic             m_flush;

    wb_retire_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) wbi ();

    wb_retire_unit #(.XLEN(XLEN), .ILEN(ILEN), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb            (wbi.slave),
        .rs0_addr_i    (rs_addr[0]),
        .rs1_addr_i    (rs_addr[1]),
        .rs2_addr_i    (rs_addr[2]),
        .rs3_addr_i    (rs_addr[3]),
        .rs0_data_o    (rs_data[0]),
        .rs1_data_o    (rs_data[1]),
        .rs2_data_o    (rs_data[2]),
        .rs3_data_o    (rs_data[3]),
        .flush_o       (flush),
        .instret_o     (instret),
        .retire_pc_o   (retire_pc),
        .retire_inst_o (retire_inst)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        wbi.inst0_wb_valid_i = 0; wbi.inst0_wb_rd_i = 0;
        wbi.inst0_wb_value_i = 0; wbi.inst0_wb_pc_i = 0;
        wbi.inst0_wb_inst_i = 0;
        wbi.inst1_wb_valid_i = 0; wbi.inst1_wb_rd_i = 0;
        wbi.inst1_wb_value_i = 0; wbi.inst1_wb_pc_i = 0;
        wbi.inst1_wb_inst_i = 0;
        wbi.wb_redirect_i = 0; wbi.wb_redirect_pc_i = 0;
        wbi.fetch_redirect_ready_i = 0;
        for (int p = 0; p < 4; p++) rs_addr[p] = 0;
    endtask

    task automatic slot(input int s, input logic [4:0] rd,
                        input logic [XLEN-1:0] val);
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] iw;
        pc = {$urandom, $urandom};
        iw = $urandom;
        if (s == 0) begin
            wbi.inst0_wb_valid_i = 1; wbi.inst0_wb_rd_i = rd;
            wbi.inst0_wb_value_i = val; wbi.inst0_wb_pc_i = pc;
            wbi.inst0_wb_inst_i = iw;
        end else begin
            wbi.inst1_wb_valid_i = 1; wbi.inst1_wb_rd_i = rd;
            wbi.inst1_wb_value_i = val; wbi.inst1_wb_pc_i = pc;
            wbi.inst1_wb_inst_i = iw;
        end
    endtask

    // Apply the retire rules to the model for the current inputs, then clock.
    task automatic tick();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            m_cnt = 0; m_rpc = 0; m_rinst = 0;
            m_hold = 0; m_pc = 0; m_flush = 0;
        end else if (!m_hold) begin
            if (wbi.inst0_wb_valid_i && wbi.inst0_wb_rd_i != 0)
                m_rf[wbi.inst0_wb_rd_i] = wbi.inst0_wb_value_i;
            if (wbi.inst1_wb_valid_i && wbi.inst1_wb_rd_i != 0)
                m_rf[wbi.inst1_wb_rd_i] = wbi.inst1_wb_value_i;
            m_cnt = CNT_W'((int'(m_cnt) + int'(wbi.inst0_wb_valid_i)
                    + int'(wbi.inst1_wb_valid_i)) % 256);
            if (wbi.inst1_wb_valid_i) begin
                m_rpc = wbi.inst1_wb_pc_i; m_rinst = wbi.inst1_wb_inst_i;
            end else if (wbi.inst0_wb_valid_i) begin
                m_rpc = wbi.inst0_wb_pc_i; m_rinst = wbi.inst0_wb_inst_i;
            end
            m_flush = wbi.wb_redirect_i;
            if (wbi.wb_redirect_i) begin
                m_hold = 1; m_pc = wbi.wb_redirect_pc_i;
            end
        end else begin
            m_flush = 0;
            if (wbi.fetch_redirect_ready_i) m_hold = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!m_hold) begin
            if (wbi.inst1_wb_valid_i && wbi.inst1_wb_rd_i == a)
                return wbi.inst1_wb_value_i;
            if (wbi.inst0_wb_valid_i && wbi.inst0_wb_rd_i == a)
                return wbi.inst0_wb_value_i;
        end
`endif
        return m_rf[a];
    endfunction

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        tick(); tick();
        rst_n = 1;
        #1;
        n_checks++;
        if (instret !== 0) $display("FAIL reset_instret got %0d want 0", instret);
        else n_pass++;
        n_checks++;
        if (wbi.fetch_redirect_valid_o !== 0 || flush !== 0)
            $display("FAIL reset_redirect got v=%b f=%b want 0 0",
                     wbi.fetch_redirect_valid_o, flush);
        else n_pass++;
        n_checks++;
        if (retire_pc !== 0 || retire_inst !== 0 || wbi.fetch_redirect_pc_o !== 0)
            $display("FAIL reset_retire got pc=%h inst=%h rpc=%h want 0",
                     retire_pc, retire_inst, wbi.fetch_redirect_pc_o);
        else n_pass++;
        for (int i = 0; i < 32; i += 8) begin
            rs_addr[0] = 5'(i + 1); rs_addr[1] = 5'(i + 3);
            rs_addr[2] = 5'(i + 5); rs_addr[3] = 5'(i + 7);
            #1;
            for (int p = 0; p < 4; p++) begin
                n_checks++;
                if (rs_data[p] !== 0)
                    $display("FAIL reset_reg x%0d got %h want 0", rs_addr[p], rs_data[p]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_basic();
        idle_inputs();
        slot(0, 5'd5, 64'hAA);
        tick();
        idle_inputs();
        rs_addr[0] = 5;
        #1;
        n_checks++;
        if (rs_data[0] !== 64'hAA || instret !== 1)
            $display("FAIL write_x5 got %h/%0d want aa/1", rs_data[0], instret);
        else n_pass++;
        n_checks++;
        if (retire_pc !== m_rpc || retire_inst !== m_rinst)
            $display("FAIL retire_slot0 got %h/%h want %h/%h",
                     retire_pc, retire_inst, m_rpc, m_rinst);
        else n_pass++;
        slot(0, 5'd7, 64'h11);
        slot(1, 5'd7, 64'h22);
        tick();
        idle_inputs();
        rs_addr[1] = 7;
        #1;
        n_checks++;
        if (rs_data[1] !== 64'h22 || instret !== 3)
            $display("FAIL same_rd got %h/%0d want 22/3", rs_data[1], instret);
        else n_pass++;
        n_checks++;
        if (retire_pc !== m_rpc || retire_inst !== m_rinst)
            $display("FAIL retire_slot1 got %h/%h want %h/%h",
                     retire_pc, retire_inst, m_rpc, m_rinst);
        else n_pass++;
        slot(0, 5'd0, 64'hFF);
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rs_data[0] !== 0 || instret !== 4)
            $display("FAIL x0_write got %h/%0d want 0/4", rs_data[0], instret);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] want;
        idle_inputs();
        slot(0, 5'd3, 64'h5);
        rs_addr[1] = 3;
        #1;
        want = exp_read(5'd3);
        n_checks++;
        if (rs_data[1] !== want)
            $display("FAIL bypass_x3 got %h want %h", rs_data[1], want);
        else n_pass++;
        tick();
        idle_inputs();
        rs_addr[1] = 3;
        #1;
        n_checks++;
        if (rs_data[1] !== 64'h5)
            $display("FAIL after_write_x3 got %h want 5", rs_data[1]);
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic [CNT_W-1:0] cnt0;
        idle_inputs();
        cnt0 = m_cnt;
        wbi.wb_redirect_i = 1;
        wbi.wb_redirect_pc_i = 64'h8000_0100;
        slot(0, 5'd9, 64'h99);
        tick();
        idle_inputs();
        n_checks++;
        if (wbi.fetch_redirect_valid_o !== 1 || flush !== 1
            || wbi.fetch_redirect_pc_o !== 64'h8000_0100)
            $display("FAIL redirect_enter got v=%b f=%b pc=%h want 1 1 80000100",
                     wbi.fetch_redirect_valid_o, flush, wbi.fetch_redirect_pc_o);
        else n_pass++;
        n_checks++;
        if (instret !== cnt0 + 8'd1)
            $display("FAIL redirect_retires got %0d want %0d", instret, cnt0 + 8'd1);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            slot(0, 5'd9, 64'hDEAD);
            slot(1, 5'd10, 64'hBEEF);
            wbi.wb_redirect_i = 1;
            wbi.wb_redirect_pc_i = 64'h1234;
            tick();
            n_checks++;
            if (wbi.fetch_redirect_valid_o !== 1 || flush !== 0
                || wbi.fetch_redirect_pc_o !== 64'h8000_0100
                || instret !== cnt0 + 8'd1 || retire_pc !== m_rpc)
                $display("FAIL hold_%0d got v=%b f=%b pc=%h cnt=%0d want 1 0 80000100 %0d",
                         c, wbi.fetch_redirect_valid_o, flush,
                         wbi.fetch_redirect_pc_o, instret, cnt0 + 8'd1);
            else n_pass++;
        end
        idle_inputs();
        rs_addr[0] = 9; rs_addr[1] = 10;
        wbi.fetch_redirect_ready_i = 1;
        #1;
        n_checks++;
        if (rs_data[0] !== 64'h99 || rs_data[1] !== 0)
            $display("FAIL hold_no_write got %h/%h want 99/0", rs_data[0], rs_data[1]);
        else n_pass++;
        tick();
        wbi.fetch_redirect_ready_i = 0;
        n_checks++;
        if (wbi.fetch_redirect_valid_o !== 0 || flush !== 0)
            $display("FAIL redirect_exit got v=%b f=%b want 0 0",
                     wbi.fetch_redirect_valid_o, flush);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        idle_inputs();
        wbi.wb_redirect_i = 1;
        wbi.wb_redirect_pc_i = 64'h4000;
        tick();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        slot(0, 5'd4, 64'h44);
        tick();
        idle_inputs();
        rs_addr[0] = 4;
        #1;
        n_checks++;
        if (wbi.fetch_redirect_valid_o !== 0 || instret !== 1 || rs_data[0] !== 64'h44)
            $display("FAIL reset_mid_hold got v=%b cnt=%0d x4=%h want 0 1 44",
                     wbi.fetch_redirect_valid_o, instret, rs_data[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [XLEN-1:0] want;
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            if ($urandom_range(3) != 0)
                slot(0, 5'($urandom_range(31)), {$urandom, $urandom});
            if ($urandom_range(3) != 0)
                slot(1, 5'($urandom_range(31)), {$urandom, $urandom});
            if ($urandom_range(7) == 0) begin
                wbi.wb_redirect_i = 1;
                wbi.wb_redirect_pc_i = {$urandom, $urandom};
            end
            wbi.fetch_redirect_ready_i = ($urandom_range(2) == 0);
            for (int p = 0; p < 4; p++) rs_addr[p] = 5'($urandom_range(31));
            #1;
            for (int p = 0; p < 4; p++) begin
                want = exp_read(rs_addr[p]);
                n_checks++;
                if (rs_data[p] !== want)
                    $display("FAIL rnd_read c%0d p%0d x%0d got %h want %h",
                             c, p, rs_addr[p], rs_data[p], want);
                else n_pass++;
            end
            tick();
            n_checks++;
            if (instret !== m_cnt || retire_pc !== m_rpc || retire_inst !== m_rinst)
                $display("FAIL rnd_retire c%0d got %0d/%h/%h want %0d/%h/%h",
                         c, instret, retire_pc, retire_inst, m_cnt, m_rpc, m_rinst);
            else n_pass++;
            n_checks++;
            if (wbi.fetch_redirect_valid_o !== m_hold || flush !== m_flush
                || (m_hold && wbi.fetch_redirect_pc_o !== m_pc))
                $display("FAIL rnd_redirect c%0d got v=%b f=%b pc=%h want %b %b %h",
                         c, wbi.fetch_redirect_valid_o, flush,
                         wbi.fetch_redirect_pc_o, m_hold, m_flush, m_pc);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] want;
        idle_inputs();
        wbi.fetch_redirect_ready_i = 1;
        if (m_hold) tick();
        while (m_cnt != 8'hFF) begin
            idle_inputs();
            slot(0, 5'd0, 0);
            tick();
        end
        idle_inputs();
        slot(0, 5'd1, 64'h1);
        slot(1, 5'd2, 64'h2);
        tick();
        want = 8'd1;
        n_checks++;
        if (instret !== want)
            $display("FAIL instret_wrap got %0d want %0d", instret, want);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_bypass();
        test_redirect();
        test_reset_mid_hold();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
